// File: rtl/sm_pkg.sv
// Shared definitions for the 4-bit sign-magnitude adder datapath and its checkers.
// Values are {sign, magnitude[2:0]}; +0 and -0 may be treated as equal.
package sm_pkg;

    localparam int SM_W   = 4;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic sm_equal(input logic [SM_W-1:0] x,
                                      input logic [SM_W-1:0] y,
                                      input logic            zero_equiv);
        logic both_zero;
        both_zero = (x[SM_W-2:0] == '0) && (y[SM_W-2:0] == '0);
        return (x == y) || (zero_equiv && both_zero);
    endfunction

endpackage

// File: rtl/sm_delay_line.sv
// {valid, addr, sum} shift register, DEPTH stages; flush drops every valid bit.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module sm_delay_line
    import sm_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [SM_W-1:0]   in_sum,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic [SM_W-1:0]   out_sum
);

    logic [DEPTH-1:0]             vld_q,  vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][SM_W-1:0]   sum_q,  sum_d;

    always_comb begin
        vld_d     = vld_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        vld_d[0]  = in_vld;
        addr_d[0] = in_addr;
        sum_d[0]  = in_sum;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
            sum_d[i]  = sum_q[i-1];
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
            sum_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            sum_q  <= sum_d;
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];
    assign out_sum  = sum_q[DEPTH-1];

endmodule

// File: rtl/sm_add_bist.sv
// Sweeps all 256 {a,b} pairs, compares adder result (delayed ROM_LAT) against ROM output.
// Start-to-done latency 256+ROM_LAT cycles; one address per cycle, never stalls.
module sm_add_bist
    import sm_pkg::*;
#(
    parameter int ROM_LAT    = 1,
    parameter bit ZERO_EQUIV = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [SM_W-1:0]   a,
    output logic [SM_W-1:0]   b,
    input  logic [SM_W-1:0]   sum_comb,
    input  logic [SM_W-1:0]   sum_rom,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [8:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);

    localparam logic [2:0]        DRAIN_LAST = 3'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [8:0]        ERR_MAX    = 9'd256;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [2:0]        drain_q, drain_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              pass_q,  pass_d;
    logic [8:0]        err_q,   err_d;
    logic [ADDR_W-1:0] fea_q,   fea_d;
    logic              fev_q,   fev_d;

    logic              launch;
    logic              dl_in_vld;
    logic              dl_vld;
    logic [ADDR_W-1:0] dl_addr;
    logic [SM_W-1:0]   dl_sum;
    logic              mismatch;

    assign launch    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign dl_in_vld = (state_q == ST_SWEEP);
    assign mismatch  = dl_vld && !sm_equal(dl_sum, sum_rom, ZERO_EQUIV);

    sm_delay_line #(.DEPTH(ROM_LAT)) u_delay (
        .clk      (clk),
        .rst_n    (reset_n),
        .flush    (launch),
        .in_vld   (dl_in_vld),
        .in_addr  (addr_q),
        .in_sum   (sum_comb),
        .out_vld  (dl_vld),
        .out_addr (dl_addr),
        .out_sum  (dl_sum)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fea_d   = fea_q;
        fev_d   = fev_q;

        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 9'd1;
            end
            if (!fev_q) begin
                fea_d = dl_addr;
                fev_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d = ST_SWEEP;
                    addr_d  = '0;
                    err_d   = '0;
                    fea_d   = '0;
                    fev_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Final compare lands on the same edge as the DONE transition.
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fea_q   <= '0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            fev_q   <= fev_d;
        end
    end

    assign a               = addr_q[ADDR_W-1:SM_W];
    assign b               = addr_q[SM_W-1:0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = fea_q;
    assign first_err_valid = fev_q;

endmodule

// File: tb/tb_sm_add_bist.sv
// Three BIST instances (lat1/ze1, lat1/ze0, lat2/ze1) share one ROM table and stimulus.
module tb_sm_add_bist;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] a_o [3];
    logic [3:0] b_o [3];
    logic [3:0] sc  [3];
    logic [3:0] sr  [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic       fev_o  [3];
    logic [8:0] err_o  [3];
    logic [7:0] fea_o  [3];
    logic [3:0] rom_p2;
    logic [3:0] rom_tab [256];

    int checks = 0;
    int errors = 0;
    int ze_of  [3] = '{1, 0, 1};
    int lat_of [3] = '{1, 1, 2};

    function automatic int sm_to_int(input logic [3:0] x);
        return x[3] ? -int'(x[2:0]) : int'(x[2:0]);
    endfunction

    function automatic logic [3:0] int_to_sm(input int v);
        int m;
        m = (v < 0 ? -v : v) % 8;
        if (m == 0) return 4'b0000;
        return {(v < 0), 3'(m)};
    endfunction

    function automatic logic [3:0] gold(input logic [7:0] ad);
        return int_to_sm(sm_to_int(ad[7:4]) + sm_to_int(ad[3:0]));
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) sc[i] = gold({a_o[i], b_o[i]});
    end

    always @(posedge clk) begin
        sr[0]  <= rom_tab[{a_o[0], b_o[0]}];
        sr[1]  <= rom_tab[{a_o[1], b_o[1]}];
        rom_p2 <= rom_tab[{a_o[2], b_o[2]}];
        sr[2]  <= rom_p2;
    end

    sm_add_bist #(.ROM_LAT(1), .ZERO_EQUIV(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a_o[0]), .b(b_o[0]),
        .sum_comb(sc[0]), .sum_rom(sr[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_count(err_o[0]), .first_err_addr(fea_o[0]),
        .first_err_valid(fev_o[0]));
    sm_add_bist #(.ROM_LAT(1), .ZERO_EQUIV(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a_o[1]), .b(b_o[1]),
        .sum_comb(sc[1]), .sum_rom(sr[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_count(err_o[1]), .first_err_addr(fea_o[1]),
        .first_err_valid(fev_o[1]));
    sm_add_bist #(.ROM_LAT(2), .ZERO_EQUIV(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a_o[2]), .b(b_o[2]),
        .sum_comb(sc[2]), .sum_rom(sr[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .err_count(err_o[2]), .first_err_addr(fea_o[2]),
        .first_err_valid(fev_o[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clean_rom();
        for (int i = 0; i < 256; i++) rom_tab[i] = gold(8'(i));
    endtask

    // Reference: numeric equality when -0/+0 merge, bitwise otherwise; ascending order.
    task automatic model(input int ze, output int cnt, output int first);
        logic [3:0] g;
        logic [3:0] r;
        bit eq;
        cnt = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            g  = gold(8'(i));
            r  = rom_tab[i];
            eq = (ze != 0) ? (sm_to_int(g) == sm_to_int(r)) : (g == r);
            if (!eq) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int mid_start, output int c0,
                             output int c1, output int c2);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c0 = -1; c1 = -1; c2 = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (cyc == 1) begin
                chk({tag, "_busy_c1"}, int'(busy_o[0]), 1);
                chk({tag, "_err_clr"}, int'(err_o[0]), 0);
                chk({tag, "_fev_clr"}, int'(fev_o[0]), 0);
            end
            if (done_o[0] && c0 < 0) c0 = cyc;
            if (done_o[1] && c1 < 0) c1 = cyc;
            if (done_o[2] && c2 < 0) c2 = cyc;
            if (cyc == mid_start) start = 1'b1;
            if (c0 >= 0 && c1 >= 0 && c2 >= 0) break;
        end
    endtask

    task automatic check_results(input string tag, input int c0, input int c1, input int c2);
        int cnt, first;
        int cy [3];
        cy = '{c0, c1, c2};
        for (int i = 0; i < 3; i++) begin
            model(ze_of[i], cnt, first);
            chk($sformatf("%s_u%0d_cycles", tag, i), cy[i], 256 + lat_of[i]);
            chk($sformatf("%s_u%0d_busy", tag, i), int'(busy_o[i]), 0);
            chk($sformatf("%s_u%0d_err", tag, i), int'(err_o[i]), cnt);
            chk($sformatf("%s_u%0d_pass", tag, i), int'(pass_o[i]), (cnt == 0) ? 1 : 0);
            chk($sformatf("%s_u%0d_fev", tag, i), int'(fev_o[i]), (cnt > 0) ? 1 : 0);
            if (cnt > 0) chk($sformatf("%s_u%0d_fea", tag, i), int'(fea_o[i]), first);
        end
    endtask

    initial begin
        int c0, c1, c2, n, ad;
        clean_rom();
        #22;
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_done", int'(done_o[0]), 0);
        chk("rst_err", int'(err_o[0]), 0);
        chk("rst_a", int'(a_o[0]), 0);
        @(negedge clk) reset_n = 1'b1;

        // Clean ROM, with a start pulse ignored mid-sweep.
        run_sweep("clean", 50, c0, c1, c2);
        check_results("clean", c0, c1, c2);

        clean_rom();
        rom_tab[8'h77] = 4'b0001;
        run_sweep("c77", 0, c0, c1, c2);
        check_results("c77", c0, c1, c2);
        chk("c77_fea_const", int'(fea_o[0]), 8'h77);

        clean_rom();
        rom_tab[8'h2A] = 4'b1000;
        run_sweep("negz", 0, c0, c1, c2);
        check_results("negz", c0, c1, c2);
        chk("negz_ze1_err", int'(err_o[0]), 0);
        chk("negz_ze0_err", int'(err_o[1]), 1);
        chk("negz_ze0_fea", int'(fea_o[1]), 8'h2A);

        for (int i = 0; i < 256; i++) rom_tab[i] = ~gold(8'(i));
        run_sweep("inv", 0, c0, c1, c2);
        check_results("inv", c0, c1, c2);
        chk("inv_err256", int'(err_o[0]), 256);
        chk("inv_fea0", int'(fea_o[0]), 0);

        for (int r = 0; r < 5; r++) begin
            clean_rom();
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) begin
                ad = $urandom_range(0, 255);
                rom_tab[ad] = 4'($urandom);
            end
            run_sweep($sformatf("rnd%0d", r), (r == 2) ? $urandom_range(2, 250) : 0, c0, c1, c2);
            check_results($sformatf("rnd%0d", r), c0, c1, c2);
        end

        // Reset in the middle of a sweep, then a fresh full sweep.
        clean_rom();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_a", int'(a_o[0]), 4'h6);
        chk("mid_b", int'(b_o[0]), 4'h4);
        reset_n = 1'b0;
        #1;
        chk("arst_a", int'(a_o[0]), 0);
        chk("arst_b", int'(b_o[0]), 0);
        chk("arst_busy", int'(busy_o[0]), 0);
        chk("arst_done", int'(done_o[0]), 0);
        chk("arst_pass", int'(pass_o[0]), 0);
        chk("arst_err", int'(err_o[0]), 0);
        chk("arst_fea", int'(fea_o[0]), 0);
        chk("arst_fev", int'(fev_o[0]), 0);
        chk("arst_busy_u2", int'(busy_o[2]), 0);
        @(negedge clk) reset_n = 1'b1;
        run_sweep("post_rst", 0, c0, c1, c2);
        check_results("post_rst", c0, c1, c2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_add_bist.md
# sm_add_bist

Self-test controller for the 4-bit sign-magnitude adder datapath. It sweeps all 256 operand pairs {a, b} into the combinational adder and the synchronous lookup ROM in parallel. It aligns the adder result to the ROM read latency, compares the two, and reports a mismatch count and the first failing address. It sits on both sides of the adder/ROM pair: upstream as the operand source, downstream as the result consumer.

## Interface
Parameters:
- ROM_LAT, 1: ROM read latency in cycles (1..4); also the depth of the internal alignment delay.
- ZERO_EQUIV, 1: when 1, +0 (4'b0000) and -0 (4'b1000) compare equal.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- a  out  4  operand A (sign-magnitude), equal to addr[7:4].
- b  out  4  operand B (sign-magnitude), equal to addr[3:0].
- sum_comb  in  4  combinational adder result for the current {a, b}.
- sum_rom  in  4  ROM output, valid ROM_LAT cycles after {a, b}.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count == 0.
- err_count  out  9  mismatches in the last sweep, 0..256.
- first_err_addr  out  8  {a, b} of the first mismatch.
- first_err_valid  out  1  first_err_addr holds a captured address.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE -> SWEEP when start = 1. On this transition: addr = 0, err_count = 0, first_err_valid = 0, delay line flushed.
- SWEEP:
  - addr increments by 1 every cycle.
  - Each cycle, sum_comb and addr enter a ROM_LAT-deep delay line, tagged with a valid bit.
  - After addr = 255 is presented, go to DRAIN. addr holds at 255; it does not wrap.
- DRAIN: stay for ROM_LAT cycles, then go to DONE.
- DONE:
  - All results hold.
  - start = 1 restarts the sweep, with the same clears as IDLE -> SWEEP.
- Compare rule: applies whenever the delay-line output valid bit is high.
  - Mismatch is delayed sum_comb != sum_rom.
  - When ZERO_EQUIV = 1, both values in {0000, 1000} also count as equal.
  - Overflow results (e.g. 7+7, -7+-7) are compared bitwise with no special case.
- On a mismatch, err_count increments; it saturates at 256.
- On the first mismatch only, first_err_addr is set to the delayed addr and first_err_valid goes to 1.
- start while busy is ignored.
- Reset values (asynchronous reset, any state): state IDLE, a = b = 0, busy = done = pass = 0, err_count = 0, first_err_addr = 0, first_err_valid = 0, delay-line valid bits = 0.
- Reset mid-sweep abandons the sweep. The next start runs a full fresh sweep.

## Timing
- Edge k samples start = 1. addr = 0 is driven after edge k, and address n is driven after edge k+n.
- The compare for address n occurs at edge k+n+1+ROM_LAT.
- The last compare is at edge k+256+ROM_LAT. At that same edge: done, pass and the final err_count become valid, and busy falls.
- Start-to-done latency: 256+ROM_LAT cycles (257 for the default ROM_LAT).
- Throughput: one address per cycle, no stalls.
- err_count and first_err_* update on the compare edge. They are readable mid-sweep but are final only with done.

## Structure
- Shared package sm_pkg holds:
  - the state enum typedef;
  - constants SM_W = 4, ADDR_W = 8;
  - function sm_equal(x, y, zero_equiv).
  The sign-magnitude adder and any checker in the design reuse this package.
- Sub-module sm_delay_line: a parameterized {valid, addr, sum} shift register of depth ROM_LAT, with asynchronous active-low clear.
- The top level holds the FSM, address counter and compare/accumulate logic.

## Test plan
- Correct adder and ROM models, default parameters, start pulse -> busy for 257 cycles; then done = 1, pass = 1, err_count = 0, first_err_valid = 0.
- ROM model corrupted at addr 8'h77 (returns 4'b0001) -> err_count = 1, first_err_addr = 8'h77, first_err_valid = 1, pass = 0.
- ROM returns 4'b1000 where the adder returns 4'b0000 (addr 8'h2A, i.e. 2 + -2):
  - ZERO_EQUIV = 1 -> err_count = 0.
  - ZERO_EQUIV = 0 -> err_count = 1, first_err_addr = 8'h2A.
- Every ROM entry inverted -> err_count = 256, first_err_addr = 8'h00, pass = 0.
- reset_n low while addr = 100 -> all outputs 0 immediately, state IDLE. A new start then gives a full 257-cycle sweep with pass = 1.
- start asserted at sweep cycle 50 -> ignored, done still at cycle 257. start in DONE -> counters clear and a new sweep runs. ROM_LAT = 2 -> done at cycle 258, pass = 1.
